// File: rtl/cavlc_seq_ctrl.sv
// rtl/cavlc_seq_ctrl.sv - CAVLC encoder block sequencer with stage-to-packer pass-through
//
// Purpose:
//    Runs zigzag scan for MAX_COEFF cycles, latches the block statistics, then
//    walks coeff_token, t1 sign, levels, total_zeros and run_before, skipping
//    stages that carry no syntax for the block. The selected stage's words are
//    forwarded combinationally to the bitstream packer.
//
// Ports:
//    CLK, RST                 clock, asynchronous active-low reset
//    START                    start one block (accepted in IDLE only)
//    BUSY, DONE               not-idle level, end-of-block pulse
//    zigzag_en                high during the zigzag scan
//    total_coeff/trailing_ones/total_zeros   block statistics, latched in STATS
//    stage_en, mux_sel        one-hot stage enable and active stage index (7 = none)
//    stg_valid/code/len/last  word from the selected stage
//    stg_ready                word consumed this cycle
//    pk_valid/ready/code/len  word to the packer
//    err_count                sticky protocol/level-count error for the block

module cavlc_seq_ctrl #(
   parameter int MAX_COEFF = 16,
   parameter int CODE_W    = 16,
   parameter int LEN_W     = 5,
   parameter int CNT_W     = $clog2(MAX_COEFF + 1)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic              zigzag_en,
   input  logic [CNT_W-1:0]  total_coeff,
   input  logic [1:0]        trailing_ones,
   input  logic [CNT_W-1:0]  total_zeros,
   output logic [4:0]        stage_en,
   input  logic              stg_valid,
   input  logic [CODE_W-1:0] stg_code,
   input  logic [LEN_W-1:0]  stg_len,
   input  logic              stg_last,
   output logic              stg_ready,
   output logic              pk_valid,
   input  logic              pk_ready,
   output logic [CODE_W-1:0] pk_code,
   output logic [LEN_W-1:0]  pk_len,
   output logic [2:0]        mux_sel,
   output logic              err_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_ZIGZAG, S_STATS, S_CT, S_T1, S_LEV, S_TZ, S_RUN, S_FIN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CNT_W-1:0] r_zz_cnt;
   logic [CNT_W-1:0] r_tc;
   logic [1:0]       r_t1;
   logic [CNT_W-1:0] r_tz;
   logic [CNT_W:0]   r_lev_cnt;
   logic             r_err;

   logic     w_stage;
   logic     w_xfer;
   logic     w_adv;
   logic     w_skip_t1;
   logic     w_skip_lev;
   logic     w_skip_tz;
   logic     w_skip_run;
   logic     w_zz_last;
   logic     w_lev_err;
   logic [CNT_W:0] w_lev_exp;
   logic [CNT_W:0] w_lev_next;
   state_t   w_after_ct;
   state_t   w_after_t1;
   state_t   w_after_lev;
   state_t   w_after_tz;

   assign w_stage = (r_state == S_CT) || (r_state == S_T1) || (r_state == S_LEV) ||
                    (r_state == S_TZ) || (r_state == S_RUN);
   assign w_xfer  = stg_valid && stg_ready;
   assign w_adv   = w_xfer && stg_last;

   assign w_zz_last  = (r_zz_cnt == CNT_W'(MAX_COEFF - 1));
   assign w_skip_t1  = (r_t1 == 2'd0);
   assign w_skip_lev = (r_tc == CNT_W'(r_t1));
   assign w_skip_tz  = (r_tc == '0) || (r_tc == CNT_W'(MAX_COEFF));
   assign w_skip_run = (r_tc <= CNT_W'(1)) || (r_tz == '0);

   // Successor chains: each stage falls through to the first non-skipped later stage.
   assign w_after_tz  = !w_skip_run ? S_RUN : S_FIN;
   assign w_after_lev = !w_skip_tz  ? S_TZ  : w_after_tz;
   assign w_after_t1  = !w_skip_lev ? S_LEV : w_after_lev;
   assign w_after_ct  = (r_tc == '0) ? S_FIN : (!w_skip_t1 ? S_T1 : w_after_t1);

   // Level words expected = tc - t1; the counter saturates so a runaway stage cannot wrap it.
   assign w_lev_exp  = {1'b0, r_tc} - (CNT_W + 1)'(r_t1);
   assign w_lev_next = (r_lev_cnt == '1) ? r_lev_cnt : r_lev_cnt + 1'b1;
   assign w_lev_err  = (stg_last && (w_lev_next != w_lev_exp)) || (w_lev_next > w_lev_exp);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (START) w_next = S_ZIGZAG;
         S_ZIGZAG: if (w_zz_last) w_next = S_STATS;
         S_STATS:  w_next = S_CT;
         S_CT:     if (w_adv) w_next = w_after_ct;
         S_T1:     if (w_adv) w_next = w_after_t1;
         S_LEV:    if (w_adv) w_next = w_after_lev;
         S_TZ:     if (w_adv) w_next = w_after_tz;
         S_RUN:    if (w_adv) w_next = S_FIN;
         S_FIN:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_zz_cnt  <= '0;
         r_tc      <= '0;
         r_t1      <= '0;
         r_tz      <= '0;
         r_lev_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && START) begin
            r_zz_cnt  <= '0;
            r_lev_cnt <= '0;
            r_err     <= 1'b0;
         end
         if (r_state == S_ZIGZAG) begin
            r_zz_cnt <= w_zz_last ? '0 : r_zz_cnt + 1'b1;
         end
         if (r_state == S_STATS) begin
            r_tc <= total_coeff;
            r_t1 <= trailing_ones;
            r_tz <= total_zeros;
         end
         if ((r_state == S_LEV) && w_xfer) begin
            r_lev_cnt <= w_lev_next;
            if (w_lev_err) r_err <= 1'b1;
         end
         // CT and TZ carry exactly one word; an extra word is flagged but tolerated.
         if (((r_state == S_CT) || (r_state == S_TZ)) && w_xfer && !stg_last) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      BUSY      = (r_state != S_IDLE);
      DONE      = (r_state == S_FIN);
      zigzag_en = (r_state == S_ZIGZAG);
      err_count = r_err;
      stage_en  = 5'b0;
      mux_sel   = 3'd7;
      case (r_state)
         S_CT:    begin stage_en = 5'b00001; mux_sel = 3'd0; end
         S_T1:    begin stage_en = 5'b00010; mux_sel = 3'd1; end
         S_LEV:   begin stage_en = 5'b00100; mux_sel = 3'd2; end
         S_TZ:    begin stage_en = 5'b01000; mux_sel = 3'd3; end
         S_RUN:   begin stage_en = 5'b10000; mux_sel = 3'd4; end
         default: begin stage_en = 5'b0;     mux_sel = 3'd7; end
      endcase
      // Zero-length words are swallowed here and never reach the packer.
      pk_valid  = w_stage && stg_valid && (stg_len != '0);
      pk_code   = w_stage ? stg_code : '0;
      pk_len    = w_stage ? stg_len  : '0;
      stg_ready = w_stage && stg_valid && (pk_ready || (stg_len == '0));
   end

endmodule
